// File: rtl/split_heads.sv
// split_heads: buffers one SEQ_LEN x HIDDEN matrix and streams it out as GROUP_NUM head-group chunks.
// Optional macro SPLIT_OVERLAP_EN lets a new matrix load on the same edge as the last chunk transfer.
module split_heads #(
   parameter int DATA_WIDTH      = 8,
   parameter int SEQ_LEN         = 128,
   parameter int HIDDEN          = 768,
   parameter int HEAD_NUM        = 12,
   parameter int HEADS_PER_GROUP = 4,
   parameter int HEAD_DIM        = 64,
   parameter int NUM_WIDTH       = 3
) (
   input  logic                                                   clk_p,
   input  logic                                                   rst_n,
   input  logic [DATA_WIDTH*SEQ_LEN*HIDDEN-1:0]                   matrix,
   input  logic                                                   input_valid_n,
   output logic                                                   input_ready_n,
   output logic [DATA_WIDTH*SEQ_LEN*HEADS_PER_GROUP*HEAD_DIM-1:0] split_matrix,
   output logic [NUM_WIDTH:0]                                     num,
   output logic                                                   output_valid_n,
   input  logic                                                   output_ready_n,
   output logic                                                   output_last_n
);

   localparam int GROUP_NUM  = HEAD_NUM / HEADS_PER_GROUP;
   localparam int CHUNK_BITS = HEADS_PER_GROUP * HEAD_DIM * DATA_WIDTH;
   localparam int ROW_BITS   = HIDDEN * DATA_WIDTH;
   localparam int MAT_BITS   = DATA_WIDTH * SEQ_LEN * HIDDEN;
   localparam logic [NUM_WIDTH:0] LAST_GROUP = (NUM_WIDTH+1)'(GROUP_NUM - 1);

   typedef enum logic {IDLE, EMIT} state_e;

   state_e                state_q, state_d;
   logic [NUM_WIDTH:0]    counter_q, counter_d;
   logic [MAT_BITS-1:0]   buffer_q, buffer_d;

   logic in_accept;
   logic out_xfer;
   logic on_last;

   // Both handshakes are active-low: a transfer happens on a rising edge where
   // valid_n and ready_n are both low; valid_n side holds its payload until then.
   always_comb begin
      on_last        = (state_q == EMIT) && (counter_q == LAST_GROUP);
      output_valid_n = (state_q != EMIT);
      output_last_n  = !on_last;
      num            = counter_q;
`ifdef SPLIT_OVERLAP_EN
      input_ready_n  = !((state_q == IDLE) || (on_last && !output_ready_n));
`else
      input_ready_n  = (state_q != IDLE);
`endif
      in_accept      = !input_valid_n && !input_ready_n;
      out_xfer       = (state_q == EMIT) && !output_ready_n;
   end

   always_comb begin
      state_d   = state_q;
      counter_d = counter_q;
      buffer_d  = buffer_q;
      if (out_xfer) begin
         if (counter_q < LAST_GROUP) begin
            counter_d = counter_q + (NUM_WIDTH+1)'(1);
         end else begin
            counter_d = '0;
            state_d   = IDLE;
         end
      end
      // An accept can only coincide with a transfer on the last chunk (overlap mode).
      if (in_accept) begin
         buffer_d  = matrix;
         counter_d = '0;
         state_d   = EMIT;
      end
   end

   always_ff @(posedge clk_p or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         counter_q <= '0;
         buffer_q  <= '0;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
         buffer_q  <= buffer_d;
      end
   end

   // Chunk row s is the contiguous column window of buffer row s picked by the counter.
   always_comb begin
      split_matrix = '0;
      for (int s = 0; s < SEQ_LEN; s++) begin
         split_matrix[s*CHUNK_BITS +: CHUNK_BITS] =
            buffer_q[s*ROW_BITS + int'(counter_q)*CHUNK_BITS +: CHUNK_BITS];
      end
   end

endmodule
